// File: rtl/ttl_reg_transceiver.sv
// Registered bidirectional bus transceiver with a turnaround guard FSM.
// Either direction can pass the live opposite bus or a captured holding register.
module ttl_reg_transceiver #(
  parameter int WIDTH       = 8,
  parameter int TURN_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             oe_n,
  input  logic             dir,
  input  logic             sel_reg,
  input  logic             cap_a,
  input  logic             cap_b,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] a_out,
  output logic             a_oe,
  output logic [WIDTH-1:0] b_out,
  output logic             b_oe,
  output logic             busy
);

  localparam int CW = $clog2(TURN_CYCLES + 1);

  localparam logic [1:0] ST_OFF  = 2'd0;
  localparam logic [1:0] ST_A2B  = 2'd1;
  localparam logic [1:0] ST_B2A  = 2'd2;
  localparam logic [1:0] ST_TURN = 2'd3;

  localparam logic [CW-1:0] TURN_LOAD = CW'(TURN_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_reg_a;
  logic [WIDTH-1:0] r_reg_b;

  logic [1:0]       w_state_next;
  logic [CW-1:0]    w_cnt_next;

  // oe_n wins over dir everywhere; a direction change always passes through TURN
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_OFF: begin
        if (!oe_n) begin
          w_state_next = dir ? ST_A2B : ST_B2A;
        end
      end
      ST_A2B: begin
        if (oe_n) begin
          w_state_next = ST_OFF;
        end else if (!dir) begin
          w_state_next = ST_TURN;
          w_cnt_next   = TURN_LOAD;
        end
      end
      ST_B2A: begin
        if (oe_n) begin
          w_state_next = ST_OFF;
        end else if (dir) begin
          w_state_next = ST_TURN;
          w_cnt_next   = TURN_LOAD;
        end
      end
      default: begin
        if (oe_n) begin
          w_state_next = ST_OFF;
          w_cnt_next   = '0;
        end else if (r_cnt == CNT_ONE) begin
          w_state_next = dir ? ST_A2B : ST_B2A;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next   = r_cnt - CNT_ONE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_OFF;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Holding registers capture in every state, independent of the FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reg_a <= '0;
      r_reg_b <= '0;
    end else begin
      if (cap_a) r_reg_a <= a_in;
      if (cap_b) r_reg_b <= b_in;
    end
  end

  always_comb begin
    b_oe  = (r_state == ST_A2B);
    a_oe  = (r_state == ST_B2A);
    busy  = (r_state == ST_TURN);
    b_out = '0;
    a_out = '0;
    if (b_oe) b_out = sel_reg ? r_reg_a : a_in;
    if (a_oe) a_out = sel_reg ? r_reg_b : b_in;
  end

endmodule

// File: tb/tb_ttl_reg_transceiver.sv
// Directed bench for ttl_reg_transceiver plus a random direction-toggle run
// on a wide instance checking the drivers are never both enabled.
module tb_ttl_reg_transceiver;

  logic       clk;
  logic       rst;
  logic       oe_n, dir, sel_reg, cap_a, cap_b;
  logic [7:0] a_in, b_in;
  logic [7:0] a_out, b_out;
  logic       a_oe, b_oe, busy;

  logic        w_oe_n, w_dir, w_sel, w_cap_a, w_cap_b;
  logic [15:0] w_a_in, w_b_in, w_a_out, w_b_out;
  logic        w_a_oe, w_b_oe, w_busy;

  int checks;
  int failures;
  int busy_seen;

  ttl_reg_transceiver #(.WIDTH(8), .TURN_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .oe_n(oe_n), .dir(dir), .sel_reg(sel_reg),
    .cap_a(cap_a), .cap_b(cap_b), .a_in(a_in), .b_in(b_in),
    .a_out(a_out), .a_oe(a_oe), .b_out(b_out), .b_oe(b_oe), .busy(busy)
  );

  ttl_reg_transceiver #(.WIDTH(16), .TURN_CYCLES(3)) dut16 (
    .clk(clk), .rst(rst), .oe_n(w_oe_n), .dir(w_dir), .sel_reg(w_sel),
    .cap_a(w_cap_a), .cap_b(w_cap_b), .a_in(w_a_in), .b_in(w_b_in),
    .a_out(w_a_out), .a_oe(w_a_oe), .b_out(w_b_out), .b_oe(w_b_oe), .busy(w_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0; failures = 0; busy_seen = 0;
    rst = 1'b1; oe_n = 1'b1; dir = 1'b1; sel_reg = 1'b0; cap_a = 1'b0; cap_b = 1'b0;
    a_in = 8'h00; b_in = 8'h00;
    w_oe_n = 1'b1; w_dir = 1'b1; w_sel = 1'b0; w_cap_a = 1'b0; w_cap_b = 1'b0;
    w_a_in = 16'h1234; w_b_in = 16'hABCD;
    tick(); tick();
    chk("rst_b_oe", {15'd0, b_oe}, 16'd0);
    chk("rst_a_oe", {15'd0, a_oe}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_a_out", {8'd0, a_out}, 16'd0);
    chk("rst_b_out", {8'd0, b_out}, 16'd0);

    // Enable A->B straight from OFF
    rst = 1'b0;
    oe_n = 1'b0; dir = 1'b1; a_in = 8'hA5; b_in = 8'hC3;
    #1;
    chk("off_b_oe_pre", {15'd0, b_oe}, 16'd0);
    tick();
    chk("a2b_b_oe", {15'd0, b_oe}, 16'd1);
    chk("a2b_b_out", {8'd0, b_out}, 16'h00A5);
    chk("a2b_a_oe", {15'd0, a_oe}, 16'd0);
    chk("a2b_a_out", {8'd0, a_out}, 16'd0);
    chk("a2b_busy", {15'd0, busy}, 16'd0);

    // Register path and same-cycle capture
    cap_a = 1'b1; a_in = 8'h3C;
    tick();
    cap_a = 1'b0; a_in = 8'hFF; sel_reg = 1'b1;
    #1;
    chk("reg_b_out_3c", {8'd0, b_out}, 16'h003C);
    a_in = 8'h11; cap_a = 1'b1;
    #1;
    chk("cap_pre_edge", {8'd0, b_out}, 16'h003C);
    tick();
    cap_a = 1'b0;
    chk("cap_post_edge", {8'd0, b_out}, 16'h0011);
    sel_reg = 1'b0; a_in = 8'h22;
    #1;
    chk("live_b_out_22", {8'd0, b_out}, 16'h0022);

    // Direction change with two-cycle turnaround
    dir = 1'b0; b_in = 8'hC3;
    tick();
    chk("turn1_b_oe", {15'd0, b_oe}, 16'd0);
    chk("turn1_a_oe", {15'd0, a_oe}, 16'd0);
    chk("turn1_busy", {15'd0, busy}, 16'd1);
    chk("turn1_b_out", {8'd0, b_out}, 16'd0);
    tick();
    chk("turn2_busy", {15'd0, busy}, 16'd1);
    chk("turn2_a_oe", {15'd0, a_oe}, 16'd0);
    tick();
    chk("b2a_busy", {15'd0, busy}, 16'd0);
    chk("b2a_a_oe", {15'd0, a_oe}, 16'd1);
    chk("b2a_a_out", {8'd0, a_out}, 16'h00C3);
    chk("b2a_b_out", {8'd0, b_out}, 16'd0);

    // Abort TURN with oe_n, then re-enable without turnaround
    dir = 1'b1;
    tick();
    chk("turn_again_busy", {15'd0, busy}, 16'd1);
    oe_n = 1'b1; dir = 1'b0;
    tick();
    chk("abort_busy", {15'd0, busy}, 16'd0);
    chk("abort_a_oe", {15'd0, a_oe}, 16'd0);
    chk("abort_b_oe", {15'd0, b_oe}, 16'd0);
    oe_n = 1'b0; dir = 1'b0;
    tick();
    chk("reen_a_oe", {15'd0, a_oe}, 16'd1);
    chk("reen_busy", {15'd0, busy}, 16'd0);

    // Async reset during B2A with a stored register
    cap_b = 1'b1; b_in = 8'h5A;
    tick();
    cap_b = 1'b0; b_in = 8'h00; sel_reg = 1'b1;
    #1;
    chk("reg_a_out_5a", {8'd0, a_out}, 16'h005A);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_a_oe", {15'd0, a_oe}, 16'd0);
    chk("arst_a_out", {8'd0, a_out}, 16'd0);
    chk("arst_reg_b", {8'd0, dut.r_reg_b}, 16'd0);
    chk("arst_busy", {15'd0, busy}, 16'd0);
    cap_a = 1'b1; a_in = 8'h77;
    tick();
    chk("rst_cap_ignored", {8'd0, dut.r_reg_a}, 16'd0);
    cap_a = 1'b0;

    // After release, first enabled edge goes straight to A2B
    rst = 1'b0; oe_n = 1'b0; dir = 1'b1; sel_reg = 1'b0; a_in = 8'h96;
    tick();
    chk("post_rst_b_oe", {15'd0, b_oe}, 16'd1);
    chk("post_rst_b_out", {8'd0, b_out}, 16'h0096);

    // Reset in the middle of TURN
    dir = 1'b0;
    tick();
    chk("mid_turn_busy", {15'd0, busy}, 16'd1);
    rst = 1'b1;
    #1;
    chk("mid_turn_rst_busy", {15'd0, busy}, 16'd0);
    tick();
    rst = 1'b0; dir = 1'b0; b_in = 8'h4E;
    tick();
    chk("mid_turn_b2a", {15'd0, a_oe}, 16'd1);
    chk("mid_turn_a_out", {8'd0, a_out}, 16'h004E);

    // Random dir/oe_n toggling on the 16-bit, 3-cycle-turnaround instance
    for (int i = 0; i < 400; i++) begin
      w_oe_n = ($urandom_range(0, 7) == 0);
      w_dir  = ($urandom_range(0, 3) == 0) ? ~w_dir : w_dir;
      tick();
      if (w_busy) busy_seen++;
      chk("rand_exclusive", {15'd0, (w_a_oe & w_b_oe)}, 16'd0);
    end
    chk("rand_busy_seen", {15'd0, (busy_seen > 0)}, 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ttl_reg_transceiver.md
TTL_REG_TRANSCEIVER -- requirements
Module: ttl_reg_transceiver

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data width of each bus side (>=1).
REQ-002 SHALL have parameter TURN_CYCLES, default 1: dead cycles on a direction change (>=1).
REQ-003 SHALL have port clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port oe_n, input, 1: active-low transceiver enable.
REQ-006 SHALL have port dir, input, 1: 1 = A->B, 0 = B->A.
REQ-007 SHALL have port sel_reg, input, 1: 0 = pass live input, 1 = pass stored register.
REQ-008 SHALL have port cap_a, input, 1: capture a_in into reg_a on the clock edge.
REQ-009 SHALL have port cap_b, input, 1: capture b_in into reg_b on the clock edge.
REQ-010 SHALL have port a_in, input, WIDTH: sensed A bus.
REQ-011 SHALL have port b_in, input, WIDTH: sensed B bus.
REQ-012 SHALL have port a_out, output, WIDTH: data driven onto A.
REQ-013 SHALL have port a_oe, output, 1: A driver enable (tri-state resolved by the generator).
REQ-014 SHALL have port b_out, output, WIDTH: data driven onto B.
REQ-015 SHALL have port b_oe, output, 1: B driver enable.
REQ-016 SHALL have port busy, output, 1: high while in TURN.

Function
REQ-017 SHALL implement an FSM with states OFF, A2B, B2A and TURN, plus a turnaround counter of width clog2(TURN_CYCLES+1).
REQ-018 In OFF, when oe_n=0, SHALL move on the next edge to A2B if dir=1, else to B2A, with no turnaround.
REQ-019 In A2B or B2A, when oe_n=1, SHALL move to OFF on the next edge; oe_n has priority over dir.
REQ-020 In A2B with dir=0, or B2A with dir=1 (oe_n=0), SHALL move to TURN and load the counter with TURN_CYCLES.
REQ-021 In TURN, SHALL decrement the counter each cycle; at count 1 with oe_n=0, SHALL enter A2B or B2A per dir sampled at that edge, so TURN lasts exactly TURN_CYCLES cycles.
REQ-022 In TURN, oe_n=1 SHALL abort to OFF on the next edge; dir toggling inside TURN SHALL NOT restart the count.
REQ-023 b_oe SHALL be 1 only in A2B, a_oe SHALL be 1 only in B2A, and both SHALL be decoded from the registered state, never both 1, and 0 in OFF and TURN.
REQ-024 busy SHALL be 1 exactly in TURN.
REQ-025 b_out SHALL equal (sel_reg ? reg_a : a_in) when b_oe=1, else all zeros; this path SHALL be combinational.
REQ-026 a_out SHALL equal (sel_reg ? reg_b : b_in) when a_oe=1, else all zeros; this path SHALL be combinational.
REQ-027 reg_a SHALL load a_in on a rising edge with cap_a=1, and reg_b SHALL load b_in with cap_b=1, in every state including OFF and TURN.
REQ-028 With a capture and sel_reg=1 in the same cycle, the output SHALL show the old register value until the edge and the new value after it.
REQ-029 Simultaneous cap_a and cap_b SHALL both load; captures SHALL be independent of the FSM.

Reset
REQ-030 While rst=1, the block SHALL immediately force state OFF, counter 0, reg_a=0, reg_b=0, a_oe=0, b_oe=0, busy=0, and a_out=b_out=0, regardless of clk.
REQ-031 Reset asserted mid-TURN or mid-transfer SHALL abort to OFF; after release, the first edge with oe_n=0 SHALL enter A2B or B2A directly with no turnaround.
REQ-032 Captures SHALL be ignored while rst=1.

Verification
REQ-033 Reset release, then oe_n=0, dir=1, sel_reg=0, a_in=8'hA5 -> one edge later b_oe=1, b_out=8'hA5, a_oe=0, a_out=8'h00.
REQ-034 In A2B with TURN_CYCLES=2, set dir=0 -> b_oe falls next edge, busy=1 for exactly 2 cycles with both oe=0, then a_oe=1 and a_out=b_in.
REQ-035 Pulse cap_a with a_in=8'h3C, change a_in to 8'hFF, then sel_reg=1 in A2B -> b_out=8'h3C; the same-cycle capture of 8'h11 shows 8'h3C before the edge and 8'h11 after.
REQ-036 In TURN, raise oe_n -> OFF next edge, busy=0, both oe=0; lower oe_n with dir=0 -> B2A after one edge, with no turnaround.
REQ-037 Assert rst asynchronously between edges during B2A with reg_b=8'h5A -> a_oe, a_out, reg_b and busy drop to 0 immediately.
REQ-038 Check both a_oe=b_oe=1 never occurs over a randomised dir/oe_n toggle run with WIDTH=16 and TURN_CYCLES=3.
